// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and bit-period helper.
// Optional build macro: UART_TX_PARITY_EN adds the even-parity state to the enum.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } uart_state_e;
`endif

    // Clock cycles per bit, truncated toward zero.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick for the last cycle of
// each bit. Held at zero while clear is high, so it never free-runs.
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_W'(DIV - 1));
    assign tick   = w_tick;

    // Count cycles within a bit; wrap on the final cycle or restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, LSB first, idle-high, 8N1 by default.
// Optional build macro: UART_TX_PARITY_EN inserts an even parity bit after d7.
// tx is registered from the next-state/next-shift values so each bit change
// lines up exactly with the state change, with no path from valid/data to tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    uart_state_e               r_state;
    uart_state_e               w_state_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic [BIT_W-1:0]          r_bit;
    logic                      r_tx;
    logic                      w_tx_next;
    logic                      w_tick;
    logic                      w_idle;
    logic                      w_accept;
    logic                      w_last_bit;
`ifdef UART_TX_PARITY_EN
    logic                      r_par;
`endif

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = valid && w_idle;
    assign w_last_bit = (r_bit == BIT_W'(UART_DATA_BITS - 1));

    assign ready = w_idle;
    assign busy  = !w_idle;
    assign tx    = r_tx;

    // Counter is held clear in IDLE, which also clears it on the accept edge.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_idle),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each non-idle state lasts whole bit periods.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (valid)  w_state_next = ST_START;
            ST_START:  if (w_tick) w_state_next = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (w_tick && w_last_bit) w_state_next = ST_PARITY;
            ST_PARITY: if (w_tick) w_state_next = ST_STOP;
`else
            ST_DATA:   if (w_tick && w_last_bit) w_state_next = ST_STOP;
`endif
            ST_STOP:   if (w_tick) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Line value for the next cycle, derived from where the FSM is heading.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_par;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    // Next shift contents: load on accept, shift right at the end of each data bit.
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept) begin
            w_shift_next = data;
        end else if ((r_state == ST_DATA) && w_tick) begin
            w_shift_next = r_shift >> 1;
        end
    end

    // Registered serial output; forced idle-high by reset at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

    // Data bit index: zero outside DATA, advances at the end of each data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= '0;
        end else if (r_state != ST_DATA) begin
            r_bit <= '0;
        end else if (w_tick) begin
            r_bit <= r_bit + BIT_W'(1);
        end
    end

    // Shift register holds the byte in flight; data path needs no reset.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the accepted byte, captured alongside it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_par <= ^data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx (default 8N1, or with UART_TX_PARITY_EN defined).
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DIV = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    int         mon_frames = 0;
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_j      = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic [7:0] mon_exp    = 8'h00;
    logic       prev_tx    = 1'b1;

    uart_tx #(
        .CLK_HZ (50_000_000),
        .BAUD   (115_200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit, pops the scoreboard at each stop bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (prev_tx && !tx) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
        end
        if (rst_n && mon_active && (mon_cnt % DIV == DIV / 2)) begin
            mon_j = mon_cnt / DIV;
            if (mon_j == 0) begin
                total++;
                if (tx !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_start cyc=%0d tx=%b want 0", cyc, tx);
                end
            end else if (mon_j <= 8) begin
                mon_byte[mon_j-1] = tx;
            end else if (mon_j == NBITS - 1) begin
                total++;
                if (tx !== 1'b1) begin
                    bad++;
                    $display("FAIL mon_stop cyc=%0d tx=%b want 1", cyc, tx);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_extra_frame cyc=%0d got %02h want none", cyc, mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp) begin
                        bad++;
                        $display("FAIL mon_byte cyc=%0d got %02h want %02h", cyc, mon_byte, mon_exp);
                    end
                end
                mon_frames++;
                mon_active = 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            else begin
                total++;
                if (tx !== ^mon_byte) begin
                    bad++;
                    $display("FAIL mon_parity cyc=%0d got %b want %b", cyc, tx, ^mon_byte);
                end
            end
`endif
        end
        prev_tx = tx;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", tx); end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_idle got tx=%b ready=%b want 1 1", tx, ready);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        logic [10:0] pat;
        int          lows;
        int          idx;
        int          c;
        logic        done;
        pat      = '1;
        pat[0]   = 1'b0;
        pat[8:1] = b;
`ifdef UART_TX_PARITY_EN
        pat[9]   = ^b;
`endif
        @(negedge clk);
        c = 0;
        while (!ready && c < 20000) begin @(negedge clk); c++; end
        if (!ready) begin
            total++; bad++;
            $display("FAIL single_wait_ready got 0 want 1");
        end
        data  = b;
        valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        valid = 1'b0;
        data  = ~b;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy byte=%02h got %b want 1", b, busy); end
        lows = 0;
        done = 1'b0;
        for (int k = 1; k <= FRAME + 100 && !done; k++) begin
            if ((k - 1) % DIV == DIV / 2) begin
                idx = (k - 1) / DIV;
                if (idx < NBITS) begin
                    total++;
                    if (tx !== pat[idx]) begin
                        bad++;
                        $display("FAIL single_bit byte=%02h bit=%0d got %b want %b", b, idx, tx, pat[idx]);
                    end
                end
            end
            if (ready) begin
                done = 1'b1;
            end else begin
                lows++;
                @(negedge clk);
            end
        end
        total++;
        if (lows !== FRAME) begin
            bad++;
            $display("FAIL single_ready_low byte=%02h got %0d want %0d", b, lows, FRAME);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_drained byte=%02h got %0d pending want 0", b, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int t0;
        int t1;
        int f0;
        @(negedge clk);
        while (!ready) @(negedge clk);
        start_q.delete();
        f0    = mon_frames;
        acc   = 0;
        t0    = 0;
        t1    = 0;
        data  = 8'h30;
        valid = 1'b1;
        for (int k = 0; k < 3 * FRAME && acc < 2; k++) begin
            if (valid && ready) begin
                exp_q.push_back(data);
                if (acc == 0) t0 = cyc; else t1 = cyc;
                acc++;
            end
            @(negedge clk);
            if (acc == 1) data = 8'h31;
        end
        valid = 1'b0;
        total++;
        if (acc !== 2) begin bad++; $display("FAIL b2b_accepts got %0d want 2", acc); end
        total++;
        if (t1 - t0 !== FRAME + 1) begin
            bad++;
            $display("FAIL b2b_accept_period got %0d want %0d", t1 - t0, FRAME + 1);
        end
        for (int k = 0; k < 2 * FRAME + 10 && (exp_q.size() != 0 || mon_active); k++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drained got %0d pending want 0", exp_q.size()); end
        total++;
        if (mon_frames - f0 !== 2) begin bad++; $display("FAIL b2b_frames got %0d want 2", mon_frames - f0); end
        total++;
        if (start_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_starts got %0d want 2", start_q.size());
        end else if (start_q[1] - start_q[0] !== FRAME + 1) begin
            bad++;
            $display("FAIL b2b_start_spacing got %0d want %0d", start_q[1] - start_q[0], FRAME + 1);
        end
    endtask

    task automatic test_hold_three();
        int acc;
        int f0;
        @(negedge clk);
        while (!ready) @(negedge clk);
        start_q.delete();
        f0    = mon_frames;
        acc   = 0;
        data  = 8'hA5;
        valid = 1'b1;
        for (int k = 0; k < 3 * (FRAME + 1); k++) begin
            if (valid && ready) begin
                exp_q.push_back(data);
                acc++;
            end
            @(negedge clk);
            data = ready ? 8'hA5 : 8'h5A;
        end
        valid = 1'b0;
        total++;
        if (acc !== 3) begin bad++; $display("FAIL hold_accepts got %0d want 3", acc); end
        for (int k = 0; k < 2 * FRAME + 10 && (exp_q.size() != 0 || mon_active); k++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL hold_drained got %0d pending want 0", exp_q.size()); end
        total++;
        if (mon_frames - f0 !== 3) begin bad++; $display("FAIL hold_frames got %0d want 3", mon_frames - f0); end
        total++;
        if (start_q.size() != 3) begin bad++; $display("FAIL hold_starts got %0d want 3", start_q.size()); end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        while (!ready) @(negedge clk);
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (1949) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL midframe_bit3 got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL midframe_reset_tx got %b want 1", tx); end
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset_ctl got ready=%b busy=%b want 1 0", ready, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            bad++;
            $display("FAIL midframe_release got ready=%b tx=%b want 1 1", ready, tx);
        end
        test_single(8'hFF);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog cyc=%0d want finish before 95000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'h31);
        test_single(8'h33);
        test_back_to_back();
        test_hold_three();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, 8N1 (optional even parity), LSB first, idle-high line. Companion to the existing `uart` receiver: accepts bytes from on-chip logic over a valid/ready handshake and serialises them onto the board's TX pin. It runs directly on the 50 MHz system clock with an internal bit-period counter, so it needs no divided clock. Intended for echo/loopback and status reporting alongside the LED demo.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115_200: line rate.
- `DIV` (localparam), CLK_HZ/BAUD truncated (434): cycles per bit.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  8  byte to send, sampled on accept.
- `valid`  in  1  `data` is offered.
- `ready`  out  1  transmitter can accept a byte this cycle.
- `tx`  out  1  serial line, registered, idle 1.
- `busy`  out  1  frame in progress (`!ready`).

## Operation
- Accept: `valid && ready` on a rising edge. `data` is latched into a shift register, and later changes to `data` are ignored.
- States (shared enum): IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx`=1, `ready`=1. On accept, go to START and clear the bit counter.
- START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for DIV cycles per bit, shifting right after each bit. After bit 7, go to PARITY or STOP.
- PARITY: `tx`=^latched byte (even parity) for DIV cycles, then go to STOP.
- STOP: `tx`=1 for DIV cycles, then go to IDLE.
- `ready` is 1 only in IDLE. `valid` held high across a frame does not cause a second accept until IDLE is re-entered.
- Bit counter: width $clog2(DIV), counts 0..DIV-1, tick at DIV-1. It is cleared on accept; it is never free-running.
- Reset (any time, including mid-frame): `tx`=1, `ready`=1, `busy`=0, state IDLE immediately (asynchronous). The partial frame is abandoned; there is no stuck-low line.

## Timing
- Accept in cycle N; `tx` falls at the edge ending cycle N (start bit visible from cycle N+1).
- Each bit lasts exactly DIV cycles; no jitter or rounding accumulation within a frame.
- Frame length: 10·DIV cycles (11·DIV with parity), measured from the first start-bit cycle to the last stop-bit cycle.
- `ready` rises in the cycle after the final stop-bit cycle. Back-to-back bytes therefore have a minimum accept-to-accept period of 10·DIV+1 cycles (11·DIV+1 with parity). The idle gap is one cycle.
- `tx` is a flop output; there is no combinational path from `valid`/`data` to `tx` or `ready`.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is present, with an even parity bit between d7 and the stop bit. Frame is 11 bits.
- Not defined: PARITY state and parity logic are absent, 8N1 only. Frame is 10 bits, matching the current receiver.

## Structure
- `uart_pkg`: state enum, `UART_DATA_BITS`=8, and a helper function for computing DIV from CLK_HZ/BAUD. The receiver reuses these later.
- Sub-module `uart_baud_gen`: DIV-cycle counter with synchronous `clear` and one-cycle `tick` output. `uart_tx` instantiates one copy.
- `uart_tx` itself contains the FSM, the shift register, and the bit index (0..7).

## Test plan
- Reset, then send 0x55 → `tx` shows 0,1,0,1,0,1,0,1,0,1 at 434-cycle spacing; `ready` is low for 4340 cycles.
- `valid` held high with 0x30 then 0x31 → two frames, start bits 4341 cycles apart, each byte sent exactly once.
- `valid` held high with constant 0xA5 for 3 frame times → exactly 3 frames; `data` changed mid-frame has no effect on the frame in flight.
- Assert `rst_n`=0 during DATA bit 3 of 0x00 → `tx`=1 in the same cycle, `ready`=1 after release, and the next byte 0xFF is sent cleanly.
- `UART_TX_PARITY_EN`, send 0x31 → parity bit 1, frame 4774 cycles; send 0x33 → parity bit 0.
- Loopback `tx` into the existing `uart` receiver (16× clock from the top-level divider), send 0x41 → receiver `valid` pulse with `out`=0x41.
